// File: rtl/multi_pulse_seq.sv
// N-channel pulse sequencer on the PLL clock: a period counter drives SYNC, repeating per-channel
// pulse trains, a receiver-inhibit window and a two-level attenuator word, all from double-buffered config.
module multi_pulse_seq #(
    parameter int NCH    = 4,
    parameter int CW     = 32,
    parameter int RW     = 8,
    parameter int ATT_W  = 7,
    parameter int SYNC_W = 16
) (
    input  logic               clk_pll,
    input  logic               reset,
    input  logic               run,
    input  logic               cfg_load,
    input  logic [CW-1:0]      cfg_period,
    input  logic [NCH*CW-1:0]  cfg_delay,
    input  logic [NCH*CW-1:0]  cfg_width,
    input  logic [CW-1:0]      cfg_space,
    input  logic [RW-1:0]      cfg_nrep,
    input  logic               cfg_blk_en,
    input  logic [CW-1:0]      cfg_blk_off,
    input  logic [CW-1:0]      cfg_att_sw,
    input  logic [ATT_W-1:0]   cfg_pre_att,
    input  logic [ATT_W-1:0]   cfg_po_att,
    output logic               sync_on,
    output logic [NCH-1:0]     pulse_on,
    output logic               inhib,
    output logic [ATT_W-1:0]   att,
    output logic               wrap,
    output logic               cfg_pend
);

    typedef struct packed {
        logic [CW-1:0]     period;
        logic [NCH*CW-1:0] delay;
        logic [NCH*CW-1:0] width;
        logic [CW-1:0]     space;
        logic [RW-1:0]     nrep;
        logic              blk_en;
        logic [CW-1:0]     blk_off;
        logic [CW-1:0]     att_sw;
        logic [ATT_W-1:0]  pre_att;
        logic [ATT_W-1:0]  po_att;
    } cfg_t;

    typedef enum logic {ST_IDLE, ST_RUN} top_state_e;
    typedef enum logic [1:0] {CH_WAIT, CH_HIGH, CH_DONE} ch_state_e;

    top_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    cfg_t          cfg_in, shadow_q, shadow_d, active_q, active_d;
    logic          cfg_pend_q, cfg_pend_d;

    ch_state_e     ch_state_q [NCH];
    ch_state_e     ch_state_d [NCH];
    logic [CW-1:0] start_q    [NCH];
    logic [CW-1:0] start_d    [NCH];
    logic [CW-1:0] hcnt_q     [NCH];
    logic [CW-1:0] hcnt_d     [NCH];
    logic [RW-1:0] reps_q     [NCH];
    logic [RW-1:0] reps_d     [NCH];

    logic             sync_on_q, sync_on_d;
    logic [NCH-1:0]   pulse_on_q, pulse_on_d;
    logic             inhib_q, inhib_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic             wrap_q, wrap_d;

    logic [CW-1:0] period_eff;
    logic [CW-1:0] width_i;
    logic [CW:0]   next_start;
    logic          at_wrap, load_ch, end_pulse;

    always_comb begin
        cfg_in         = '0;
        cfg_in.period  = cfg_period;
        cfg_in.delay   = cfg_delay;
        cfg_in.width   = cfg_width;
        cfg_in.space   = cfg_space;
        cfg_in.nrep    = cfg_nrep;
        cfg_in.blk_en  = cfg_blk_en;
        cfg_in.blk_off = cfg_blk_off;
        cfg_in.att_sw  = cfg_att_sw;
        cfg_in.pre_att = cfg_pre_att;
        cfg_in.po_att  = cfg_po_att;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = cfg_load ? cfg_in : shadow_q;
        active_d   = active_q;
        cfg_pend_d = cfg_pend_q | cfg_load;
        sync_on_d  = 1'b0;
        pulse_on_d = '0;
        inhib_d    = 1'b0;
        att_d      = '0;
        wrap_d     = 1'b0;
        load_ch    = 1'b0;
        width_i    = '0;
        end_pulse  = 1'b0;
        next_start = '0;
        period_eff = (active_q.period < CW'(2)) ? CW'(2) : active_q.period;
        at_wrap    = (count_q == period_eff - CW'(1));
        for (int i = 0; i < NCH; i++) begin
            ch_state_d[i] = ch_state_q[i];
            start_d[i]    = start_q[i];
            hcnt_d[i]     = hcnt_q[i];
            reps_d[i]     = reps_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_RUN;
                    count_d    = '0;
                    active_d   = shadow_d;
                    cfg_pend_d = 1'b0;
                    load_ch    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    load_ch = 1'b1;
                end else begin
                    sync_on_d = (count_q < CW'(SYNC_W));
                    inhib_d   = active_q.blk_en & (count_q < active_q.blk_off);
                    att_d     = (count_q < active_q.att_sw) ? active_q.pre_att : active_q.po_att;

                    for (int i = 0; i < NCH; i++) begin
                        width_i   = active_q.width[i*CW +: CW];
                        end_pulse = 1'b0;
                        case (ch_state_q[i])
                            CH_WAIT: begin
                                if (count_q == start_q[i] && width_i != '0) begin
                                    pulse_on_d[i] = 1'b1;
                                    hcnt_d[i]     = CW'(1);
                                    if (width_i == CW'(1)) end_pulse = 1'b1;
                                    else                   ch_state_d[i] = CH_HIGH;
                                end
                            end
                            CH_HIGH: begin
                                pulse_on_d[i] = 1'b1;
                                hcnt_d[i]     = hcnt_q[i] + CW'(1);
                                if (hcnt_d[i] == width_i) end_pulse = 1'b1;
                            end
                            default: ;
                        endcase
                        // A repeat only follows if it starts after this pulse ends and its start fits in CW bits.
                        if (end_pulse) begin
                            next_start = {1'b0, start_q[i]} + {1'b0, active_q.space};
                            if (reps_q[i] != '0 && active_q.space > width_i && !next_start[CW]) begin
                                ch_state_d[i] = CH_WAIT;
                                start_d[i]    = next_start[CW-1:0];
                                reps_d[i]     = reps_q[i] - RW'(1);
                            end else begin
                                ch_state_d[i] = CH_DONE;
                            end
                        end
                    end

                    if (at_wrap) begin
                        count_d    = '0;
                        wrap_d     = 1'b1;
                        active_d   = shadow_d;
                        cfg_pend_d = 1'b0;
                        load_ch    = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase

        // Period start (or stop) rearms every channel from the config that will be active next.
        if (load_ch) begin
            for (int i = 0; i < NCH; i++) begin
                ch_state_d[i] = CH_WAIT;
                start_d[i]    = active_d.delay[i*CW +: CW];
                reps_d[i]     = active_d.nrep;
                hcnt_d[i]     = '0;
            end
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            cfg_pend_q <= 1'b0;
            sync_on_q  <= 1'b0;
            pulse_on_q <= '0;
            inhib_q    <= 1'b0;
            att_q      <= '0;
            wrap_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                ch_state_q[i] <= CH_WAIT;
                start_q[i]    <= '0;
                hcnt_q[i]     <= '0;
                reps_q[i]     <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            cfg_pend_q <= cfg_pend_d;
            sync_on_q  <= sync_on_d;
            pulse_on_q <= pulse_on_d;
            inhib_q    <= inhib_d;
            att_q      <= att_d;
            wrap_q     <= wrap_d;
            for (int i = 0; i < NCH; i++) begin
                ch_state_q[i] <= ch_state_d[i];
                start_q[i]    <= start_d[i];
                hcnt_q[i]     <= hcnt_d[i];
                reps_q[i]     <= reps_d[i];
            end
        end
    end

    assign sync_on  = sync_on_q;
    assign pulse_on = pulse_on_q;
    assign inhib    = inhib_q;
    assign att      = att_q;
    assign wrap     = wrap_q;
    assign cfg_pend = cfg_pend_q;

endmodule

// File: tb/tb_multi_pulse_seq.sv
// Scoreboard bench for multi_pulse_seq: a per-cycle reference model pushes expected outputs,
// which are popped and compared one cycle later; directed checks cover period, repeat and reset cases.
module tb_multi_pulse_seq;
    localparam int NCH    = 4;
    localparam int CW     = 32;
    localparam int RW     = 8;
    localparam int ATT_W  = 7;
    localparam int SYNC_W = 16;

    typedef struct packed {
        logic [31:0]      period;
        logic [3:0][31:0] delay;
        logic [3:0][31:0] width;
        logic [31:0]      space;
        logic [7:0]       nrep;
        logic             blk_en;
        logic [31:0]      blk_off;
        logic [31:0]      att_sw;
        logic [6:0]       pre;
        logic [6:0]       po;
    } tcfg_t;

    typedef struct packed {
        logic       sync;
        logic [3:0] pulse;
        logic       inhib;
        logic [6:0] att;
        logic       wrap;
        logic       pend;
    } obs_t;

    logic clk_pll  = 1'b0;
    logic reset    = 1'b1;
    logic run      = 1'b0;
    logic cfg_load = 1'b0;
    tcfg_t drv = '0;

    logic             sync_on;
    logic [NCH-1:0]   pulse_on;
    logic             inhib;
    logic [ATT_W-1:0] att;
    logic             wrap;
    logic             cfg_pend;

    multi_pulse_seq #(
        .NCH(NCH), .CW(CW), .RW(RW), .ATT_W(ATT_W), .SYNC_W(SYNC_W)
    ) dut (
        .clk_pll    (clk_pll),
        .reset      (reset),
        .run        (run),
        .cfg_load   (cfg_load),
        .cfg_period (drv.period),
        .cfg_delay  (drv.delay),
        .cfg_width  (drv.width),
        .cfg_space  (drv.space),
        .cfg_nrep   (drv.nrep),
        .cfg_blk_en (drv.blk_en),
        .cfg_blk_off(drv.blk_off),
        .cfg_att_sw (drv.att_sw),
        .cfg_pre_att(drv.pre),
        .cfg_po_att (drv.po),
        .sync_on    (sync_on),
        .pulse_on   (pulse_on),
        .inhib      (inhib),
        .att        (att),
        .wrap       (wrap),
        .cfg_pend   (cfg_pend)
    );

    always #5 clk_pll = ~clk_pll;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hi_cnt   [4];
    int rise_cnt [4];
    logic [3:0] prev_pulse = '0;

    logic        m_run;
    logic [31:0] m_cnt;
    tcfg_t       m_sh, m_act;
    logic        m_pend;
    obs_t        sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        return {sync_on, pulse_on, inhib, att, wrap, cfg_pend};
    endfunction

    // Closed form: pulse k covers [delay + k*space, delay + k*space + width), while the start fits in 32 bits.
    function automatic bit pulse_model(tcfg_t c, int ch, logic [31:0] cnt);
        longint unsigned s, w, d, sp;
        int reps;
        w  = 64'(c.width[ch]);
        d  = 64'(c.delay[ch]);
        sp = 64'(c.space);
        if (w == 0) return 1'b0;
        reps = (sp > w) ? int'(c.nrep) : 0;
        for (int k = 0; k <= reps; k++) begin
            s = d + 64'(k) * sp;
            if (s >= 64'h1_0000_0000) return 1'b0;
            if (64'(cnt) >= s && 64'(cnt) < s + w) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_run  = 1'b0;
        m_cnt  = '0;
        m_sh   = '0;
        m_act  = '0;
        m_pend = 1'b0;
    endfunction

    function automatic obs_t model_step();
        obs_t        e;
        tcfg_t       sh_n;
        logic [31:0] p;
        e      = '0;
        sh_n   = cfg_load ? drv : m_sh;
        e.pend = m_pend | cfg_load;
        if (!m_run) begin
            if (run) begin
                m_run  = 1'b1;
                m_cnt  = '0;
                m_act  = sh_n;
                e.pend = 1'b0;
            end
        end else if (!run) begin
            m_run = 1'b0;
            m_cnt = '0;
        end else begin
            p       = (m_act.period < 32'd2) ? 32'd2 : m_act.period;
            e.sync  = (m_cnt < 32'(SYNC_W));
            for (int ch = 0; ch < NCH; ch++) e.pulse[ch] = pulse_model(m_act, ch, m_cnt);
            e.inhib = m_act.blk_en && (m_cnt < m_act.blk_off);
            e.att   = (m_cnt < m_act.att_sw) ? m_act.pre : m_act.po;
            if (m_cnt == p - 32'd1) begin
                e.wrap = 1'b1;
                m_cnt  = '0;
                m_act  = sh_n;
                e.pend = 1'b0;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        m_sh   = sh_n;
        m_pend = e.pend;
        return e;
    endfunction

    task automatic cycle();
        obs_t got, exp_o;
        sb.push_back(model_step());
        @(negedge clk_pll);
        cyc++;
        cfg_load = 1'b0;
        got   = sample();
        exp_o = sb.pop_front();
        check($sformatf("outputs@cyc%0d", cyc), 32'(got), 32'(exp_o));
        for (int i = 0; i < NCH; i++) begin
            hi_cnt[i]   += int'(pulse_on[i]);
            rise_cnt[i] += int'(pulse_on[i] & ~prev_pulse[i]);
        end
        prev_pulse = pulse_on;
    endtask

    task automatic run_n(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_wrap(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!wrap && n < 400);
        check("wrap_seen", 32'(wrap), 32'd1);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NCH; i++) begin
            hi_cnt[i]   = 0;
            rise_cnt[i] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk_pll);
        check("reset_outputs", 32'(sample()), 32'd0);
        reset = 1'b0;

        // Single pulse, sync, inhib and attenuator over a 100-cycle period.
        drv.period   = 32'd100;
        drv.delay[0] = 32'd10;
        drv.width[0] = 32'd5;
        drv.blk_en   = 1'b1;
        drv.blk_off  = 32'd30;
        drv.att_sw   = 32'd50;
        drv.pre      = 7'h15;
        drv.po       = 7'h6a;
        cfg_load = 1'b1;
        cycle();
        check("pend_in_idle", 32'(cfg_pend), 32'd1);
        run = 1'b1;
        wait_wrap(n);
        check("first_wrap_latency", n, 101);
        clear_stats();
        wait_wrap(n);
        check("period_100", n, 100);
        check("ch0_high_cycles", hi_cnt[0], 5);
        check("ch0_single_pulse", rise_cnt[0], 1);

        // Repeat trains: 4 pulses at 20/30/40/50, then space <= width collapses to one pulse.
        drv.delay[1] = 32'd20;
        drv.width[1] = 32'd4;
        drv.space    = 32'd10;
        drv.nrep     = 8'd3;
        cfg_load = 1'b1;
        cycle();
        check("pend_in_run", 32'(cfg_pend), 32'd1);
        wait_wrap(n);
        check("pend_clear_at_wrap", 32'(cfg_pend), 32'd0);
        clear_stats();
        wait_wrap(n);
        check("ch1_train_pulses", rise_cnt[1], 4);
        check("ch1_train_high", hi_cnt[1], 16);
        check("ch0_train_pulses", rise_cnt[0], 4);
        drv.space = 32'd4;
        cfg_load = 1'b1;
        cycle();
        wait_wrap(n);
        clear_stats();
        wait_wrap(n);
        check("ch1_space_eq_width", rise_cnt[1], 1);
        check("ch0_space_lt_width", rise_cnt[0], 1);

        // New period loaded mid-period applies only after the current wrap.
        run_n(30);
        drv.period = 32'd50;
        cfg_load = 1'b1;
        cycle();
        check("pend_mid_period", 32'(cfg_pend), 32'd1);
        wait_wrap(n);
        check("old_period_kept", n, 69);
        check("pend_cleared", 32'(cfg_pend), 32'd0);
        wait_wrap(n);
        check("new_period_50", n, 50);

        // Pulse crossing the wrap is cut and re-fires next period.
        drv.period   = 32'd100;
        drv.delay[2] = 32'd95;
        drv.width[2] = 32'd10;
        cfg_load = 1'b1;
        cycle();
        wait_wrap(n);
        clear_stats();
        wait_wrap(n);
        check("ch2_truncated", hi_cnt[2], 5);
        clear_stats();
        wait_wrap(n);
        check("ch2_refire", hi_cnt[2], 5);

        // Period 0 and 1 clamp to 2.
        drv.period = 32'd0;
        cfg_load = 1'b1;
        cycle();
        wait_wrap(n);
        wait_wrap(n);
        check("period0_as_2", n, 2);
        drv.period = 32'd1;
        cfg_load = 1'b1;
        cycle();
        wait_wrap(n);
        wait_wrap(n);
        check("period1_as_2", n, 2);

        // Run dropped at count 40, then restart from count 0.
        drv.period = 32'd100;
        cfg_load = 1'b1;
        cycle();
        wait_wrap(n);
        run_n(40);
        run = 1'b0;
        cycle();
        check("run_drop_outputs", 32'(sample()), 32'd0);
        run_n(3);
        run = 1'b1;
        wait_wrap(n);
        check("restart_from_zero", n, 101);

        // Asynchronous reset while a pulse is high and a config is pending.
        run_n(11);
        drv.period = 32'd77;
        cfg_load = 1'b1;
        cycle();
        check("pulse_before_reset", 32'(pulse_on[0]), 32'd1);
        check("pend_before_reset", 32'(cfg_pend), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_async_outputs", 32'(sample()), 32'd0);
        @(negedge clk_pll);
        reset = 1'b0;
        model_reset();
        sb.delete();
        prev_pulse = '0;

        // Shadow config was cleared by reset, so the period clamps to 2.
        wait_wrap(n);
        check("shadow_lost_after_reset", n, 3);
        run_n(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
